// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction fetch handshake into the ALU sequencer
interface alu_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle sequencer: accept, read operands, drive ALU, write back to Rx
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.slave   bus,
  output logic [RA_W-1:0]  rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_instr;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;

  logic             w_ready;
  logic             w_accept;
  logic [1:0]       w_fmt;
  logic [RA_W-1:0]  w_rx;
  logic [RA_W-1:0]  w_ry;
  logic [WIDTH-1:0] w_imm;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = bus.instr_valid && w_ready;
  assign w_fmt    = r_instr[1:0];
  assign w_rx     = RA_W'(r_instr[15:13]);
  assign w_ry     = RA_W'(r_instr[12:10]);
  assign w_imm    = WIDTH'(r_instr[12:5]);

  assign bus.instr_ready = w_ready;
  assign busy            = !w_ready;
  assign alu_a           = r_op_a;
  assign alu_b           = r_op_b;
  assign alu_sel         = r_instr[4:2];
  assign rf_waddr        = w_rx;
  assign rf_wdata        = r_result;
  assign result          = r_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_instr <= bus.instr;
        end
        S_LOAD_A: begin
          r_op_a <= rf_rdata;
          // immediate operand is loaded alongside Rx so immediates skip LOAD_B
          if (w_fmt == 2'b01) r_op_b <= w_imm;
        end
        S_LOAD_B: r_op_b   <= rf_rdata;
        S_EXEC:   r_result <= alu_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    rf_raddr = '0;
    rf_we    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // fmt decode here uses the live word; only bit 1 separates legal from illegal
        if (w_accept) w_next = bus.instr[1] ? S_ERR : S_LOAD_A;
      end
      S_LOAD_A: begin
        rf_raddr = w_rx;
        w_next   = (w_fmt == 2'b00) ? S_LOAD_B : S_EXEC;
      end
      S_LOAD_B: begin
        rf_raddr = w_ry;
        w_next   = S_EXEC;
      end
      S_EXEC: w_next = S_WRITE;
      S_WRITE: begin
        rf_we  = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        done   = 1'b1;
        err    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
